// File: rtl/pin_pulse_gen_if.sv
// Control-side bundle for pin_pulse_gen: one-shot start with burst parameters, pin/status back.
// abort_i exists only when PIN_PULSE_GEN_ABORT_EN is defined.
interface pin_pulse_gen_if #(
  parameter int CNT_W = 8,
  parameter int N_W   = 4
);
  logic             start_i;
  logic [N_W-1:0]   n_pulses_i;
  logic [CNT_W-1:0] low_len_i;
  logic [CNT_W-1:0] high_len_i;
  logic             pin_o;
  logic             busy_o;
  logic             done_o;
`ifdef PIN_PULSE_GEN_ABORT_EN
  logic             abort_i;
`endif

  modport master (
`ifdef PIN_PULSE_GEN_ABORT_EN
    output abort_i,
`endif
    output start_i, n_pulses_i, low_len_i, high_len_i,
    input  pin_o, busy_o, done_o
  );

  modport slave (
`ifdef PIN_PULSE_GEN_ABORT_EN
    input  abort_i,
`endif
    input  start_i, n_pulses_i, low_len_i, high_len_i,
    output pin_o, busy_o, done_o
  );
endinterface

// File: rtl/pin_pulse_gen.sv
// Idle-high pin driver emitting a burst of N active-low pulses of L low / H high cycles.
// Optional PIN_PULSE_GEN_ABORT_EN adds abort_i to cancel a burst without signalling done.
module pin_pulse_gen #(
  parameter int CNT_W = 8,
  parameter int N_W   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  pin_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [N_W-1:0]   pulse_q, pulse_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             done_q, done_d;
  logic             abort;

`ifdef PIN_PULSE_GEN_ABORT_EN
  assign abort = bus.abort_i;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      pulse_q <= '0;
      n_q     <= '0;
      low_q   <= '0;
      high_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
      n_q     <= n_d;
      low_q   <= low_d;
      high_q  <= high_d;
      done_q  <= done_d;
    end
  end

  // Phase compare precedes the increment, so a full 2^CNT_W-1 phase never wraps.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pulse_d = pulse_q;
    n_d     = n_q;
    low_d   = low_q;
    high_d  = high_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          n_d    = bus.n_pulses_i;
          low_d  = (bus.low_len_i  == '0) ? CNT_W'(1) : bus.low_len_i;
          high_d = (bus.high_len_i == '0) ? CNT_W'(1) : bus.high_len_i;
          if (bus.n_pulses_i != '0) begin
            state_d = LOW;
            phase_d = CNT_W'(1);
            pulse_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      LOW: begin
        if (abort) begin
          state_d = IDLE;
          phase_d = '0;
          pulse_d = '0;
        end else if (phase_q == low_q) begin
          state_d = HIGH;
          phase_d = CNT_W'(1);
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (abort) begin
          state_d = IDLE;
          phase_d = '0;
          pulse_d = '0;
        end else if (phase_q == high_q) begin
          // n_q is nonzero in a burst, so n_q-1 is the index of the last pulse.
          if (pulse_q == n_q - N_W'(1)) begin
            state_d = IDLE;
            phase_d = '0;
            pulse_d = '0;
            done_d  = 1'b1;
          end else begin
            state_d = LOW;
            phase_d = CNT_W'(1);
            pulse_d = pulse_q + N_W'(1);
          end
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
        pulse_d = '0;
      end
    endcase
  end

  assign bus.pin_o  = (state_q != LOW);
  assign bus.busy_o = (state_q != IDLE);
  assign bus.done_o = done_q;

endmodule
